// File: rtl/ir_key_entry.sv
// Keypad-entry engine: filters repeated IR key codes, queues digit characters as ASCII
// for the LCD writer and keeps a scrolling seven-segment history of recent digits.
module ir_key_entry #(
  parameter int unsigned         CODE_W      = 8,
  parameter int unsigned         DEPTH       = 8,
  parameter int unsigned         NUM_DIGITS  = 4,
  parameter int unsigned         HOLD_CYCLES = 5_000_000,
  parameter logic [CODE_W-1:0]   CLR_CODE    = 'h0C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          key_code,
  input  logic                       key_valid,
  input  logic                       char_ready,
  output logic [7:0]                 char_data,
  output logic                       char_valid,
  output logic [7*NUM_DIGITS-1:0]    seg_out,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = 7 * NUM_DIGITS;
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Stage 1: classify and repeat-filter the incoming key.
  logic [HW-1:0]     hold_q, hold_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic              dig_q, dig_d, clr_q, clr_d;
  logic [3:0]        val_q, val_d;
  logic              is_digit, is_clr, is_event, repeat_hit, accept;

  always_comb begin
    is_digit   = key_valid && (key_code < CODE_W'(10));
    is_clr     = key_valid && (key_code == CLR_CODE);
    is_event   = is_digit || is_clr;
    repeat_hit = (hold_q != '0) && (key_code == last_q);
    accept     = is_event && !repeat_hit;

    hold_d = hold_q;
    if (is_event) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    last_d = accept ? key_code : last_q;
    dig_d  = is_digit && accept;
    clr_d  = is_clr && accept;
    val_d  = key_code[3:0];
  end

  // Stage 2: FIFO, history and overflow update.
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d, push_char;
  logic          valid_q, valid_d, ovf_q, ovf_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          pop, full, push, we;

  always_comb begin
    pop       = valid_q && char_ready;
    full      = (cnt_q == CW'(DEPTH));
    push      = dig_q && !clr_q && (!full || pop);
    push_char = 8'h30 + {4'h0, val_q};
    rd_next   = rd_q + 1'b1;

    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    valid_d = valid_q;
    seg_d   = seg_q;
    we      = 1'b0;

    if (clr_q) begin
      // Flush wins over any pop this cycle.
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      seg_d   = '1;
    end else begin
      if (dig_q) begin
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
          seg_d[7*k +: 7] = seg_q[7*(k-1) +: 7];
        end
        seg_d[6:0] = seg7(val_q);
        if (!push) ovf_d = 1'b1;
      end
      if (push) begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_next;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      valid_d = (cnt_d != '0);
      // Head register: load the entry that becomes the new head.
      if (cnt_q == '0) begin
        if (push) data_d = push_char;
      end else if (pop) begin
        if (cnt_q == CW'(1)) begin
          if (push) data_d = push_char;
        end else begin
          data_d = mem_q[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q] <= push_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      last_q  <= '0;
      dig_q   <= 1'b0;
      clr_q   <= 1'b0;
      val_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
    end else begin
      hold_q  <= hold_d;
      last_q  <= last_d;
      dig_q   <= dig_d;
      clr_q   <= clr_d;
      val_q   <= val_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign char_data  = data_q;
  assign char_valid = valid_q;
  assign seg_out    = seg_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule
